// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and default width for the sequential arithmetic units
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_SUB    = 2'b10,
        S_FINISH = 2'b11
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per shift/subtract pair
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    state_t             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     diff;
    logic               fits;

    // rem_q carries one extra bit so the trial compare never wraps
    assign diff = rem_q - {1'b0, div_q};
    assign fits = rem_q >= {1'b0, div_q};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start && divisor != '0) begin
                    rem_d   = '0;
                    quo_d   = dividend;
                    div_d   = divisor;
                    cnt_d   = CNT_W'(WIDTH);
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = S_SHIFT;
                end else if (start) begin
                    quotient_d  = '1;
                    remainder_d = dividend;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_FINISH;
                end
            end
            S_SHIFT: begin
                {rem_d, quo_d} = {rem_q[WIDTH-1:0], quo_q, 1'b0};
                cnt_d          = cnt_q - 1'b1;
                state_d        = S_SUB;
            end
            S_SUB: begin
                rem_d   = fits ? diff : rem_q;
                quo_d   = {quo_q[WIDTH-1:1], fits};
                state_d = (cnt_q == '0) ? S_FINISH : S_SHIFT;
                if (cnt_q == '0) begin
                    quotient_d  = quo_d;
                    remainder_d = rem_d[WIDTH-1:0];
                    done_d      = 1'b1;
                end
            end
            S_FINISH: state_d = start ? S_FINISH : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_SHIFT) || (state_q == S_SUB);

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference
module tb_seq_divider;

    localparam int W    = 8;
    localparam int ONES = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         done, busy, div_by_zero;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_q, prev_r;

    seq_divider #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .done(done),
        .busy(busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one division; operands are scrambled right after the accept edge
    task automatic run(input int a, input int b, input bit hold);
        int eq, er, lat, bc;
        eq = (b == 0) ? ONES : a / b;
        er = (b == 0) ? a : a % b;
        start = 1'b0;
        @(negedge clk);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            chk("stable_quotient", quotient, prev_q);
            chk("stable_remainder", remainder, prev_r);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (b == 0) ? 0 : 16);
        chk("busy_cycles", bc, (b == 0) ? 0 : 16);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        chk("busy_at_done", busy, 0);
        if (b != 0) begin
            chk("invariant", int'(quotient) * b + int'(remainder), a);
            chk("rem_lt_div", (int'(remainder) < b) ? 1 : 0, 1);
        end
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                chk("hold_done", done, 1);
                chk("hold_busy", busy, 0);
                chk("hold_quotient", quotient, eq);
            end
        end
        prev_q = W'(eq);
        prev_r = W'(er);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dbz", div_by_zero, 0);
        prev_q = '0;
        prev_r = '0;

        run(100, 7, 1'b0);
        run(255, 1, 1'b0);
        run(5, 9, 1'b0);
        run(13, 0, 1'b0);
        run(182, 13, 1'b1);
        run(100, 7, 1'b0);

        start = 1'b0;
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_quotient", quotient, 0);
        chk("midreset_remainder", remainder, 0);
        chk("midreset_done", done, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_dbz", div_by_zero, 0);
        repeat (20) begin
            @(negedge clk);
            chk("midreset_no_done", done, 0);
            chk("midreset_idle", busy, 0);
        end
        prev_q = '0;
        prev_r = '0;
        run(200, 3, 1'b0);

        for (int i = 0; i < 1000; i++)
            run(int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential unsigned restoring divider. It is the inverse-operation companion to the shift-add multiplier in the Booth Multiplier area.
- Dividend and divisor are captured on a start handshake.
- One quotient bit is produced every two clocks (shift, then trial-subtract).
- Quotient and remainder are presented with a done flag.
- Shares the multiplier's start/done protocol so both can sit behind the same ALU sequencer.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (WIDTH >= 2)
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset, sampled on rising clk
start  input  1  request; sampled only in IDLE and FINISH
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
done  output  1  result valid
busy  output  1  high in SHIFT/SUB
div_by_zero  output  1  divisor was 0 for the current result

Behaviour:
Reset:
- Synchronous and active-high: on a rising clk with reset=1, state becomes IDLE.
- quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, counter=0.
- Reset overrides every state, including mid-operation. The partial result is discarded and no done pulse is produced.

Working registers: rem_w (WIDTH+1 bits), quo_w (WIDTH bits), div_w (WIDTH bits), counter (CNT_W bits).

States (2-bit encoding) and transitions:
- IDLE:
  - start=0: stay in IDLE.
  - start=1 and divisor!=0: rem_w=0, quo_w=dividend, div_w=divisor, counter=WIDTH; clear done and div_by_zero; go to SHIFT.
  - start=1 and divisor==0: quotient = all ones, remainder = dividend, div_by_zero=1, done=1; go to FINISH. Done is visible 1 clock after the accept edge.
- SHIFT:
  - {rem_w,quo_w} = {rem_w,quo_w} << 1 (MSB of quo_w enters the LSB of rem_w).
  - counter = counter-1; go to SUB.
- SUB:
  - If rem_w >= {1'b0,div_w}: rem_w = rem_w - div_w and quo_w[0]=1; otherwise no change (restoring).
  - If counter==0: quotient=quo_w, remainder=rem_w[WIDTH-1:0] (the values after this cycle's update), done=1; go to FINISH.
  - Otherwise go to SHIFT.
- FINISH:
  - start=1: hold (level handshake; no restart while start stays high).
  - start=0: go to IDLE.
  - done, quotient, remainder and div_by_zero keep their values through FINISH and IDLE until the next accepted start.

Latency and timing:
- Accept edge = cycle 0. done rises on edge 2*WIDTH (edge 16 for WIDTH=8).
- busy is high during exactly 2*WIDTH cycles.
- Minimum restart interval is 2*WIDTH+2 edges (FINISH needs start low for one edge).
- quotient and remainder change only on the completion edge, never during computation.
- Operand inputs may change freely after the accept edge.

Arithmetic:
- All operations are unsigned.
- rem_w is one bit wider so the compare never overflows.
- Invariant at completion: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package arith_pkg holds:
  - state localparams S_IDLE=2'b00, S_SHIFT=2'b01, S_SUB=2'b10, S_FINISH=2'b11;
  - the default WIDTH=8.
  - The multiplier family reuses this package.
- No sub-module: the datapath is a single compare/subtract inline in the FSM. Splitting it out adds no value at this size.

Test Plan:
- 100/7, pulse start → done rises exactly 16 clocks after the accept edge; quotient=14, remainder=2, div_by_zero=0; busy high for 16 cycles.
- 255/1 then 5/9, back-to-back with start dropped one cycle after done → 255 r0, then 0 r5; the previous result stays stable until the second completion.
- 13/0 → done 1 clock after accept; quotient=255, remainder=13, div_by_zero=1; busy never asserts.
- 182/13 with start held high through completion → result 14 r0; the FSM stays in FINISH with no second run until start=0, then re-accepts.
- Start 200/3, assert reset on cycle 7 for 1 clock → all outputs 0 next edge, state IDLE, no done; a subsequent 200/3 yields 66 r2.
- Random sweep of 1000 operand pairs with a scoreboard checking the completion invariant and the 16-cycle latency.
